// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, decoder FSM states and the
// position/data helpers that both the encoder and decoder rely on.
package hamming_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Hamming position p (1..7) lives at codeword bit 7-p.
    function automatic logic [SYN_W-1:0] pos2idx(input logic [SYN_W-1:0] p);
        return 3'd7 - p;
    endfunction

    // Data bits sit at positions 3, 5, 6, 7.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        return {cw[4], cw[2], cw[1], cw[0]};
    endfunction

endpackage

// File: rtl/hamming_syndrome_acc.sv
// Serial syndrome accumulator: walks positions 1..7, XOR-ing the position
// number into the syndrome whenever the presented codeword bit is set.
module hamming_syndrome_acc
    import hamming_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    input  logic             bit_in,
    output logic [SYN_W-1:0] idx,
    output logic [SYN_W-1:0] syndrome,
    output logic             last
);

    logic [SYN_W-1:0] syn_q, syn_d;
    logic [SYN_W-1:0] idx_q, idx_d;

    // Next syndrome/position: clear restarts at position 1, step accumulates.
    always_comb begin
        syn_d = syn_q;
        idx_d = idx_q;
        if (clear) begin
            syn_d = '0;
            idx_d = 3'd1;
        end else if (step) begin
            if (bit_in) begin
                syn_d = syn_q ^ idx_q;
            end
            idx_d = idx_q + 3'd1;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syn_q <= '0;
            idx_q <= '0;
        end else begin
            syn_q <= syn_d;
            idx_q <= idx_d;
        end
    end

    assign idx      = idx_q;
    assign syndrome = syn_q;
    assign last     = (idx_q == 3'd7);

endmodule

// File: rtl/hamming74_decoder.sv
// Bit-serial Hamming(7,4) decoder with start/busy/done handshake.
// state | meaning
// IDLE  | waiting for start; done pulse lives here
// ACC   | accumulating syndrome, one position per clock (idx 1..7)
// FIX   | correct addressed bit, register outputs, pulse done
module hamming74_decoder
    import hamming_pkg::*;
#(
    parameter bit CORRECT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CW_W-1:0]   de_in,
    output logic [DATA_W-1:0] de_out,
    output logic [SYN_W-1:0]  syndrome,
    output logic              err_flag,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [CW_W-1:0]     cw_q, cw_d;
    logic [DATA_W-1:0]   de_out_q, de_out_d;
    logic [SYN_W-1:0]    syndrome_q, syndrome_d;
    logic                err_flag_q, err_flag_d;
    logic                done_q, done_d;

    logic                acc_clear, acc_step, acc_bit, acc_last;
    logic [SYN_W-1:0]    acc_idx, acc_syn;
    logic [CW_W:0]       cw_ext, cw_fix_ext;
    logic [CW_W-1:0]     cw_fix;

    hamming_syndrome_acc u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (acc_clear),
        .step     (acc_step),
        .bit_in   (acc_bit),
        .idx      (acc_idx),
        .syndrome (acc_syn),
        .last     (acc_last)
    );

    // Padding to 8 bits keeps idx 0 (outside ACC) a legal select.
    assign cw_ext  = {1'b0, cw_q};
    assign acc_bit = cw_ext[pos2idx(acc_idx)];

    // Single-bit correction at the position named by the syndrome.
    always_comb begin
        cw_fix_ext = cw_ext;
        if (CORRECT_EN && (acc_syn != '0)) begin
            cw_fix_ext[pos2idx(acc_syn)] = ~cw_ext[pos2idx(acc_syn)];
        end
        cw_fix = cw_fix_ext[CW_W-1:0];
    end

    // FSM next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cw_d       = cw_q;
        de_out_d   = de_out_q;
        syndrome_d = syndrome_q;
        err_flag_d = err_flag_q;
        done_d     = 1'b0;
        acc_clear  = 1'b0;
        acc_step   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cw_d      = de_in;
                    acc_clear = 1'b1;
                    state_d   = ACC;
                end
            end
            ACC: begin
                acc_step = 1'b1;
                if (acc_last) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                de_out_d   = extract_data(cw_fix);
                syndrome_d = acc_syn;
                err_flag_d = |acc_syn;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cw_q       <= '0;
            de_out_q   <= '0;
            syndrome_q <= '0;
            err_flag_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cw_q       <= cw_d;
            de_out_q   <= de_out_d;
            syndrome_q <= syndrome_d;
            err_flag_q <= err_flag_d;
            done_q     <= done_d;
        end
    end

    assign de_out   = de_out_q;
    assign syndrome = syndrome_q;
    assign err_flag = err_flag_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_hamming74_decoder.sv
// Bench for hamming74_decoder: a correcting and a detect-only instance share
// stimulus; expectations come from an encoder plus a parity-check model.
module tb_hamming74_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] de_in = '0;

    logic [3:0] de_out_c, de_out_r;
    logic [2:0] syn_c, syn_r;
    logic       err_c, err_r, busy_c, busy_r, done_c, done_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hamming74_decoder #(.CORRECT_EN(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .de_in(de_in),
        .de_out(de_out_c), .syndrome(syn_c), .err_flag(err_c),
        .busy(busy_c), .done(done_c)
    );

    hamming74_decoder #(.CORRECT_EN(1'b0)) dut_r (
        .clk(clk), .rst_n(rst_n), .start(start), .de_in(de_in),
        .de_out(de_out_r), .syndrome(syn_r), .err_flag(err_r),
        .busy(busy_r), .done(done_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: encoder from data, parity-check equations for the syndrome.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[3] ^ d[2] ^ d[0];
        p2 = d[3] ^ d[1] ^ d[0];
        p4 = d[2] ^ d[1] ^ d[0];
        return {p1, p2, d[3], p4, d[2], d[1], d[0]};
    endfunction

    function automatic logic [2:0] model_syn(input logic [6:0] c);
        logic s0, s1, s2;
        s0 = c[6] ^ c[4] ^ c[2] ^ c[0];
        s1 = c[5] ^ c[4] ^ c[1] ^ c[0];
        s2 = c[3] ^ c[2] ^ c[1] ^ c[0];
        return {s2, s1, s0};
    endfunction

    function automatic logic [3:0] raw_data(input logic [6:0] c);
        return {c[4], c[2], c[1], c[0]};
    endfunction

    function automatic logic [3:0] fixed_data(input logic [6:0] c);
        logic [2:0] s;
        logic [6:0] f;
        s = model_syn(c);
        f = c;
        if (s != 0) f = c ^ (7'b1000000 >> (s - 1));
        return raw_data(f);
    endfunction

    // Call at a negedge in IDLE; returns at the negedge where done is seen.
    task automatic run_decode(input logic [6:0] cw, output int lat);
        start = 1'b1;
        de_in = cw;
        @(negedge clk);
        start = 1'b0;
        de_in = 7'($urandom);
        check("busy_after_accept", {31'b0, busy_c}, 32'd1);
        lat = 0;
        while (!done_c && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_both(input string tag, input logic [6:0] cw);
        check({tag, "_syn"},     {29'b0, syn_c},    {29'b0, model_syn(cw)});
        check({tag, "_err"},     {31'b0, err_c},    {31'b0, model_syn(cw) != 0});
        check({tag, "_data"},    {28'b0, de_out_c}, {28'b0, fixed_data(cw)});
        check({tag, "_syn_r"},   {29'b0, syn_r},    {29'b0, model_syn(cw)});
        check({tag, "_data_r"},  {28'b0, de_out_r}, {28'b0, raw_data(cw)});
        check({tag, "_done_r"},  {31'b0, done_r},   32'd1);
    endtask

    task automatic count_dones(input string tag, input int cycles);
        int n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done_c) n++;
        end
        check(tag, n, 0);
    endtask

    initial begin
        int lat;
        logic [3:0] d;
        int e;
        logic [6:0] cw;

        #1;
        check("rst_de_out", {28'b0, de_out_c}, 32'd0);
        check("rst_busy", {31'b0, busy_c}, 32'd0);
        check("rst_done", {31'b0, done_c}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors with spec-given results.
        run_decode(7'b0110011, lat);
        check("clean_latency", lat, 8);
        check("clean_data", {28'b0, de_out_c}, 32'b1011);
        check("clean_syn", {29'b0, syn_c}, 32'd0);
        check("clean_err", {31'b0, err_c}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'b0, done_c}, 32'd0);

        run_decode(7'b0110111, lat);
        check("pos5_latency", lat, 8);
        check("pos5_syn", {29'b0, syn_c}, 32'b101);
        check("pos5_err", {31'b0, err_c}, 32'd1);
        check("pos5_data", {28'b0, de_out_c}, 32'b1011);
        check("pos5_detect_data", {28'b0, de_out_r}, 32'b1111);
        check("pos5_detect_syn", {29'b0, syn_r}, 32'b101);
        check("pos5_detect_err", {31'b0, err_r}, 32'd1);
        repeat (3) @(negedge clk);
        check("hold_data", {28'b0, de_out_c}, 32'b1011);

        run_decode(7'b1110011, lat);
        check("pos1_syn", {29'b0, syn_c}, 32'b001);
        check("pos1_data", {28'b0, de_out_c}, 32'b1011);
        check("pos1_err", {31'b0, err_c}, 32'd1);

        // Back-to-back: start held in the done cycle.
        run_decode(7'b0000000, lat);
        check("b2b_latency", lat, 8);
        check("b2b_data", {28'b0, de_out_c}, 32'd0);
        check("b2b_syn", {29'b0, syn_c}, 32'd0);

        run_decode(7'b1010011, lat);
        check("dbl_syn", {29'b0, syn_c}, 32'b011);
        check("dbl_data", {28'b0, de_out_c}, 32'b0011);
        @(negedge clk);

        // Start re-pulsed while busy must be ignored.
        start = 1'b1;
        de_in = 7'b1110011;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        de_in = 7'b0000000;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!done_c && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("busy_ignore_latency", lat, 8);
        check("busy_ignore_syn", {29'b0, syn_c}, 32'b001);
        count_dones("busy_ignore_single_done", 12);

        // Asynchronous reset in the middle of ACC (idx = 4).
        run_decode(7'b1010011, lat);
        @(negedge clk);
        start = 1'b1;
        de_in = 7'b0110111;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {31'b0, busy_c}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", {28'b0, de_out_c}, 32'd0);
        check("mid_rst_syn", {29'b0, syn_c}, 32'd0);
        check("mid_rst_err", {31'b0, err_c}, 32'd0);
        check("mid_rst_busy", {31'b0, busy_c}, 32'd0);
        check("mid_rst_data_r", {28'b0, de_out_r}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones("mid_rst_no_done", 12);
        run_decode(7'b0110111, lat);
        check("post_rst_latency", lat, 8);
        check_both("post_rst", 7'b0110111);

        // Random encoded words with at most one injected error.
        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            d = 4'($urandom);
            e = $urandom_range(0, 7);
            cw = encode(d);
            if (e != 0) cw = cw ^ (7'b1000000 >> (e - 1));
            run_decode(cw, lat);
            check("rnd_latency", lat, 8);
            check("rnd_syn_vs_pos", {29'b0, syn_c}, e);
            check("rnd_data_vs_src", {28'b0, de_out_c}, {28'b0, d});
            check_both("rnd", cw);
        end

        // Fully random words, including multi-bit errors.
        for (int it = 0; it < 30; it++) begin
            cw = 7'($urandom);
            run_decode(cw, lat);
            check("rndw_latency", lat, 8);
            check_both("rndw", cw);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming74_decoder.md
Name: hamming74_decoder

Overview:
Bit-serial Hamming(7,4) single-error-correcting decoder and the receive-side counterpart of the team's Hamming encoder.
- Accepts a 7-bit codeword in the encoder's output bit order.
- Accumulates the 3-bit syndrome one codeword position per clock, corrects a single-bit error, and returns the 4 data bits.
- Sits between the codeword source (link/switch input) and the data consumer, with a start/busy/done handshake.

Parameters:
CORRECT_EN, 1, 1 = flip the bit addressed by a nonzero syndrome; 0 = detect only, data passed uncorrected.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset: asynchronous, active-low
start  in  1  request; sampled only in IDLE
de_in  in  7  codeword; sampled on the edge that accepts start
de_out  out  4  decoded data {d3,d2,d1,d0}
syndrome  out  3  final syndrome (position of the erroneous bit, 0 = clean)
err_flag  out  1  syndrome nonzero
busy  out  1  high whenever state != IDLE
done  out  1  one-clock pulse; outputs valid from this cycle

Behaviour:
- Codeword bit order: de_in[7-p] holds Hamming position p (p = 1..7).
  - Parity positions: p1 = de_in[6], p2 = de_in[5], p4 = de_in[3].
  - Data positions: d3 = de_in[4] (pos 3), d2 = de_in[2] (pos 5), d1 = de_in[1] (pos 6), d0 = de_in[0] (pos 7).
- Reset (rst_n low, any time, including mid-decode):
  - state = IDLE; cw_reg, idx and syn_acc cleared.
  - de_out = 0, syndrome = 0, err_flag = 0, busy = 0, done = 0.
  - Decode is abandoned; no done is produced.
- FSM states: IDLE, ACC, FIX.
- IDLE:
  - If start = 1 at edge E0: cw_reg <= de_in, syn_acc <= 0, idx <= 1, go to ACC.
  - Otherwise remain in IDLE.
  - done is cleared on every edge in which FIX is not the current state.
- ACC, edges E1..E7 (idx = 1..7):
  - If cw_reg[7-idx] = 1, then syn_acc <= syn_acc XOR idx.
  - idx increments; the 3-bit counter wraps only after 7, never reaching 0 inside ACC.
  - At E7 (idx = 7), go to FIX.
- FIX, edge E8:
  - If CORRECT_EN = 1 and syn_acc != 0, flip cw_reg[7-syn_acc].
  - Register de_out from the corrected word: {cw[4],cw[2],cw[1],cw[0]}.
  - Register syndrome = syn_acc, err_flag = |syn_acc, done <= 1; go to IDLE.
- Latency: done is high in the cycle following E8, i.e. 8 clocks after the accepting edge.
  - busy is high E0 to E8. Throughput is one codeword per 9 clocks.
- de_out, syndrome and err_flag hold their values until the next FIX or reset.
- start while busy is ignored; no queueing.
- start high in the done cycle (state IDLE) is accepted, giving back-to-back operation.
- de_in changes after E0 have no effect.
- Double-bit errors are not detected. They produce a nonzero syndrome and a miscorrection (SEC only, by design).

Decomposition:
- Package hamming_pkg holds:
  - CW_W = 7, DATA_W = 4, SYN_W = 3
  - state enum {IDLE, ACC, FIX}
  - position-to-index function pos2idx(p) = 7-p
  - data extraction function (shared with the encoder).
- One natural sub-module: hamming_syndrome_acc. It owns syn_acc and idx, with clear, step and bit-in inputs, and syndrome and last outputs. The FSM and correction stay in the top level.

Test Plan:
- Clean word: de_in = 7'b0110011, start pulse -> done 8 clocks later, de_out = 4'b1011, syndrome = 3'b000, err_flag = 0.
- Data-bit error at position 5: de_in = 7'b0110111 -> syndrome = 3'b101, err_flag = 1, de_out = 4'b1011.
- Parity-bit error at position 1: de_in = 7'b1110011 -> syndrome = 3'b001, err_flag = 1, de_out = 4'b1011.
- Detect-only and double error:
  - CORRECT_EN = 0, de_in = 7'b0110111 -> de_out = 4'b1111, syndrome = 3'b101, err_flag = 1.
  - CORRECT_EN = 1, de_in = 7'b1010011 -> syndrome = 3'b011, de_out = 4'b0011 (documented miscorrection).
- Handshake:
  - start re-pulsed during busy -> ignored, single done.
  - start held in the done cycle with de_in = 7'b0000000 -> second decode gives de_out = 0, syndrome = 0.
- Reset mid-operation: rst_n low at ACC idx = 4 -> all outputs 0 immediately (asynchronous), no done; a new start after release decodes correctly.
